jtag_test_if_mc: RTL and testbench
==================================

Name: jtag_test_if_mc

Overview:
- Multi-channel, parametrised successor to the single-lane JTAG test interface.
- Holds a length-checked test control register (TCR) loaded through SAMPLE_PRELOAD.
- The TCR gives each of NCH functional signal lanes an independent override mode: pass, force TDI, force 0/1, or PRBS7 pattern. One selectable lane is mirrored onto the debug chain.
- Provides an EXTEST data register with a separate update holding stage, so outputs never ripple during shifting.
- Sits between the TAP controller and the analog/digital lane boundary.

Parameters:
- NCH, 4, number of overridable lanes (1..8).
- SELW, 2, width of debug lane select; must satisfy 2^SELW >= NCH.
- CONRLEN, 32, TCR length; must be >= 3*NCH+SELW+2.
- TRLEN, 16, EXTEST data register length (>= 2).

Ports:
- tclk  in  1  JTAG test clock; the only clock, all state on posedge.
- test_logic_reset_i  in  1  synchronous, active-high reset.
- shift_dr_i  in  1  TAP in Shift-DR.
- capture_dr_i  in  1  TAP in Capture-DR.
- update_dr_i  in  1  TAP in Update-DR.
- sample_preload_sel  in  1  TCR selected.
- extest_sel  in  1  EXTEST register selected.
- chiptdi  in  1  serial data from TAP.
- bs_chain_tdi_o  out  1  serial out of the selected register.
- debug_tdi_o  out  1  mirrored lane output.
- ch_func_in  in  NCH  functional lane inputs.
- ch_out  out  NCH  muxed lane outputs.
- tcr_out  out  CONRLEN  committed TCR.
- trcal_tr_in  in  TRLEN  EXTEST capture data.
- trcal_tr_out  out  TRLEN  EXTEST update holding register.
- length_err_o  out  1  sticky length-error flag.

Behaviour:
- Reset (synchronous, sampled on posedge tclk when test_logic_reset_i=1) clears:
  - tcr=0, tcr_shift=0, tr_shift=0, trcal_tr_out=0.
  - shift_cnt=0, length_err_o=0, lfsr=7'h7F.
  - Reset overrides every other input in that cycle, including mid-shift.
- TCR layout:
  - bit0 = global enable GEN.
  - Lane i mode M_i = tcr[1+3i +: 3].
  - Debug select DSEL = tcr[3*NCH+1 +: SELW].
  - Bit CONRLEN-1 = write flag, always stored as 0.
  - Remaining bits are stored but have no function.
- Lane mux, combinational from the committed tcr. When GEN=0 every lane is pass. When GEN=1:
  - M=0 pass (ch_func_in[i]).
  - M=1 chiptdi.
  - M=2 constant 0.
  - M=3 constant 1.
  - M=4 lfsr[0].
  - M=5..7 pass.
- debug_tdi_o = GEN ? ch_out[DSEL] : 0. When DSEL >= NCH, debug_tdi_o = 0.
- PRBS7 generator:
  - Polynomial x^7+x^6+1, advances once per tclk only while GEN=1 and at least one lane has M=4; otherwise holds.
  - Never reaches all-zero.
- TCR operations (sample_preload_sel=1). Priority when several TAP strobes are high: capture > shift > update.
  - Capture: tcr_shift <= {length_err_o, tcr[CONRLEN-2:0]}; shift_cnt <= 0.
  - Shift: right shift, chiptdi enters the MSB. shift_cnt increments and saturates at CONRLEN+1.
  - Update: commits tcr <= {1'b0, tcr_shift[CONRLEN-2:0]} only when shift_cnt==CONRLEN and tcr_shift[CONRLEN-1]==1.
    - A successful commit clears length_err_o.
    - When shift_cnt != CONRLEN, length_err_o is set and tcr holds.
    - When shift_cnt==CONRLEN but the MSB is 0, this is a read: tcr holds and length_err_o is unchanged.
  - Committed tcr drives the lane muxes on the cycle after the update edge (1-cycle latency).
- EXTEST operations (extest_sel=1):
  - Capture: tr_shift <= trcal_tr_in.
  - Shift: right shift with chiptdi into the MSB.
  - Update: trcal_tr_out <= tr_shift. trcal_tr_out is constant at all other times.
- bs_chain_tdi_o, combinational:
  - extest_sel ? tr_shift[0] : sample_preload_sel ? tcr_shift[0] : 0.
  - If both selects are high, EXTEST has priority for output and neither register shifts.
- Strobes arriving with no select high are ignored.

Test Plan:
- Reset, then hold ch_func_in=4'b1010 → ch_out=4'b1010, debug_tdi_o=0, tcr_out=0, length_err_o=0.
- Shift 32 bits with MSB=1, GEN=1, M0=3, M1=2, M2=1, M3=0, DSEL=2, then update → next cycle ch_out[0]=1, ch_out[1]=0, ch_out[2]=chiptdi, ch_out[3]=ch_func_in[3], debug_tdi_o=chiptdi, tcr_out[31]=0.
- Shift 31 bits then update → tcr unchanged, length_err_o=1. Capture then shift out → first 31 bits equal tcr, 32nd bit=1. A correct 32-bit write afterwards clears length_err_o.
- Set M0=4 on lane 0 and run 127 cycles → ch_out[0] matches a PRBS7 reference from seed 7'h7F and repeats with period 127. Clear GEN → lfsr freezes.
- EXTEST: capture trcal_tr_in=16'hA5C3 and shift 16 cycles with chiptdi=1 → bs_chain_tdi_o emits LSB-first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. trcal_tr_out stays 0 throughout shifting, then becomes 16'hFFFF after update.
- Assert test_logic_reset_i mid-shift (cycle 10 of 32) → all registers return to reset values on the next edge; a following update with no new shifts sets length_err_o=1 and leaves tcr=0.

Source files
------------

// File: rtl/jtag_test_if_mc_if.sv
// TAP-side bundle for jtag_test_if_mc: Shift/Capture/Update strobes, register
// selects and serial data in both directions.
interface jtag_test_if_mc_if;
    logic shift_dr_i;
    logic capture_dr_i;
    logic update_dr_i;
    logic sample_preload_sel;
    logic extest_sel;
    logic chiptdi;
    logic bs_chain_tdi_o;

    modport master (
        output shift_dr_i, capture_dr_i, update_dr_i,
        output sample_preload_sel, extest_sel, chiptdi,
        input  bs_chain_tdi_o
    );

    modport slave (
        input  shift_dr_i, capture_dr_i, update_dr_i,
        input  sample_preload_sel, extest_sel, chiptdi,
        output bs_chain_tdi_o
    );
endinterface

// File: rtl/jtag_test_if_mc.sv
// Multi-lane JTAG test interface: length-checked TCR with per-lane override
// muxes, PRBS7 source, debug lane mirror and an EXTEST register with update stage.

module jtag_lane_mux (
    input  logic       gen,
    input  logic [2:0] mode,
    input  logic       func_in,
    input  logic       tdi,
    input  logic       prbs,
    output logic       lane_out
);
    always_comb begin
        lane_out = func_in;
        if (gen) begin
            case (mode)
                3'd1:    lane_out = tdi;
                3'd2:    lane_out = 1'b0;
                3'd3:    lane_out = 1'b1;
                3'd4:    lane_out = prbs;
                default: lane_out = func_in;
            endcase
        end
    end
endmodule

module jtag_test_if_mc #(
    parameter int NCH     = 4,
    parameter int SELW    = 2,
    parameter int CONRLEN = 32,
    parameter int TRLEN   = 16
) (
    input  logic                tclk,
    input  logic                test_logic_reset_i,
    jtag_test_if_mc_if.slave    tap,
    input  logic [NCH-1:0]      ch_func_in,
    output logic [NCH-1:0]      ch_out,
    output logic [CONRLEN-1:0]  tcr_out,
    input  logic [TRLEN-1:0]    trcal_tr_in,
    output logic [TRLEN-1:0]    trcal_tr_out,
    output logic                length_err_o,
    output logic                debug_tdi_o
);
    localparam int             CW      = $clog2(CONRLEN + 2);
    localparam logic [CW-1:0]  CNT_LEN = CW'(CONRLEN);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CONRLEN + 1);

    logic [CONRLEN-1:0]     tcr;
    logic [CONRLEN-1:0]     tcr_shift;
    logic [TRLEN-1:0]       tr_shift;
    logic [CW-1:0]          shift_cnt;
    logic [6:0]             lfsr;

    logic                   gen;
    logic [NCH-1:0][2:0]    lane_mode;
    logic [SELW-1:0]        dsel;
    logic                   prbs_en;
    logic [(1<<SELW)-1:0]   dbg_vec;

    assign gen     = tcr[0];
    assign dsel    = tcr[3*NCH+1 +: SELW];
    assign tcr_out = tcr;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            assign lane_mode[gi] = tcr[1+3*gi +: 3];
            jtag_lane_mux u_lane (
                .gen      (gen),
                .mode     (lane_mode[gi]),
                .func_in  (ch_func_in[gi]),
                .tdi      (tap.chiptdi),
                .prbs     (lfsr[0]),
                .lane_out (ch_out[gi])
            );
        end
    endgenerate

    // PRBS only runs while some lane is actually consuming it.
    always_comb begin
        prbs_en = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (lane_mode[i] == 3'd4) prbs_en = 1'b1;
        prbs_en = prbs_en & gen;
    end

    // Zero-padded so unused select codes read back as 0.
    always_comb begin
        dbg_vec          = '0;
        dbg_vec[NCH-1:0] = ch_out;
    end
    assign debug_tdi_o = gen & dbg_vec[dsel];

    // Strobe decode: capture > shift > update; EXTEST wins when both selects
    // are high and then neither register shifts.
    logic tcr_act, tcr_cap, tcr_shf, tcr_upd;
    logic tr_cap, tr_shf, tr_upd;

    assign tcr_act = tap.sample_preload_sel & ~tap.extest_sel;
    assign tcr_cap = tcr_act & tap.capture_dr_i;
    assign tcr_shf = tcr_act & ~tap.capture_dr_i & tap.shift_dr_i;
    assign tcr_upd = tcr_act & ~tap.capture_dr_i & ~tap.shift_dr_i & tap.update_dr_i;

    assign tr_cap  = tap.extest_sel & tap.capture_dr_i;
    assign tr_shf  = tap.extest_sel & ~tap.sample_preload_sel & ~tap.capture_dr_i & tap.shift_dr_i;
    assign tr_upd  = tap.extest_sel & ~tap.capture_dr_i & ~tap.shift_dr_i & tap.update_dr_i;

    assign tap.bs_chain_tdi_o = tap.extest_sel         ? tr_shift[0]  :
                                tap.sample_preload_sel ? tcr_shift[0] : 1'b0;

    always_ff @(posedge tclk) begin
        if (test_logic_reset_i) begin
            tcr          <= '0;
            tcr_shift    <= '0;
            tr_shift     <= '0;
            trcal_tr_out <= '0;
            shift_cnt    <= '0;
            length_err_o <= 1'b0;
            lfsr         <= 7'h7F;
        end else begin
            // x^7 + x^6 + 1; all-zero is unreachable from a nonzero seed.
            if (prbs_en)
                lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};

            if (tcr_cap) begin
                tcr_shift <= {length_err_o, tcr[CONRLEN-2:0]};
                shift_cnt <= '0;
            end else if (tcr_shf) begin
                tcr_shift <= {tap.chiptdi, tcr_shift[CONRLEN-1:1]};
                if (shift_cnt != CNT_MAX)
                    shift_cnt <= shift_cnt + CW'(1);
            end else if (tcr_upd) begin
                // Exact length with write flag commits; exact length without it is a read.
                if (shift_cnt == CNT_LEN) begin
                    if (tcr_shift[CONRLEN-1]) begin
                        tcr          <= {1'b0, tcr_shift[CONRLEN-2:0]};
                        length_err_o <= 1'b0;
                    end
                end else begin
                    length_err_o <= 1'b1;
                end
            end

            if (tr_cap)
                tr_shift <= trcal_tr_in;
            else if (tr_shf)
                tr_shift <= {tap.chiptdi, tr_shift[TRLEN-1:1]};
            else if (tr_upd)
                trcal_tr_out <= tr_shift;
        end
    end
endmodule

// File: tb/tb_jtag_test_if_mc.sv
// Directed bench for jtag_test_if_mc: TCR write/read/length error, lane muxes,
// PRBS7 sequence and freeze, EXTEST capture/shift/update, mid-shift reset.
module tb_jtag_test_if_mc;
    localparam int NCH = 4, SELW = 2, CONRLEN = 32, TRLEN = 16;

    logic                tclk = 1'b0;
    logic                test_logic_reset_i;
    logic [NCH-1:0]      ch_func_in;
    logic [NCH-1:0]      ch_out;
    logic [CONRLEN-1:0]  tcr_out;
    logic [TRLEN-1:0]    trcal_tr_in;
    logic [TRLEN-1:0]    trcal_tr_out;
    logic                length_err_o;
    logic                debug_tdi_o;

    always #5 tclk = ~tclk;

    jtag_test_if_mc_if tap ();

    jtag_test_if_mc #(.NCH(NCH), .SELW(SELW), .CONRLEN(CONRLEN), .TRLEN(TRLEN)) dut (
        .tclk               (tclk),
        .test_logic_reset_i (test_logic_reset_i),
        .tap                (tap),
        .ch_func_in         (ch_func_in),
        .ch_out             (ch_out),
        .tcr_out            (tcr_out),
        .trcal_tr_in        (trcal_tr_in),
        .trcal_tr_out       (trcal_tr_out),
        .length_err_o       (length_err_o),
        .debug_tdi_o        (debug_tdi_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_tcr;
    logic [31:0] pend_tcr;
    logic        pend;
    logic [6:0]  m;
    logic        prbs_ref [127];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    function automatic logic prbs_run(input logic [31:0] t);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (t[1+3*i +: 3] == 3'd4) r = 1'b1;
        return t[0] & r;
    endfunction

    // One clock; keeps the reference PRBS state in step with the committed TCR.
    task automatic tick();
        @(posedge tclk);
        if (test_logic_reset_i) begin
            m = 7'h7F; exp_tcr = '0; pend = 1'b0;
        end else begin
            if (prbs_run(exp_tcr)) m = prbs_next(m);
            if (pend) begin exp_tcr = pend_tcr; pend = 1'b0; end
        end
        #1;
    endtask

    task automatic tcr_write(input logic [31:0] v, input int n);
        tap.sample_preload_sel = 1'b1;
        tap.capture_dr_i = 1'b1;
        tick();
        tap.capture_dr_i = 1'b0;
        tap.shift_dr_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tap.chiptdi = v[i % 32];
            tick();
        end
        tap.shift_dr_i = 1'b0;
        tap.update_dr_i = 1'b1;
        if (n == 32 && v[31]) begin pend = 1'b1; pend_tcr = {1'b0, v[30:0]}; end
        tick();
        tap.update_dr_i = 1'b0;
        tap.sample_preload_sel = 1'b0;
        tap.chiptdi = 1'b0;
        #1;
    endtask

    task automatic tcr_read(output logic [31:0] w);
        tap.sample_preload_sel = 1'b1;
        tap.capture_dr_i = 1'b1;
        tick();
        tap.capture_dr_i = 1'b0;
        tap.shift_dr_i = 1'b1;
        tap.chiptdi = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1 w[i] = tap.bs_chain_tdi_o;
            tick();
        end
        tap.shift_dr_i = 1'b0;
        tap.update_dr_i = 1'b1;
        tick();
        tap.update_dr_i = 1'b0;
        tap.sample_preload_sel = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] ex_bits;

        tap.shift_dr_i = 0; tap.capture_dr_i = 0; tap.update_dr_i = 0;
        tap.sample_preload_sel = 0; tap.extest_sel = 0; tap.chiptdi = 0;
        trcal_tr_in = '0;
        ch_func_in = 4'b1010;
        pend = 1'b0; exp_tcr = '0; pend_tcr = '0; m = 7'h7F;
        test_logic_reset_i = 1'b1;
        tick(); tick();
        test_logic_reset_i = 1'b0;
        #1;

        // Reset state
        chk("rst_ch_out", ch_out, 4'b1010);
        chk("rst_debug", debug_tdi_o, 0);
        chk("rst_tcr", tcr_out, 0);
        chk("rst_err", length_err_o, 0);
        chk("rst_tr_out", trcal_tr_out, 0);
        chk("rst_bs", tap.bs_chain_tdi_o, 0);

        // GEN=1, M0=3, M1=2, M2=1, M3=0, DSEL=2, write flag set
        tcr_write(32'h800040A7, 32);
        chk("wr_tcr", tcr_out, 32'h000040A7);
        chk("wr_err", length_err_o, 0);
        tap.chiptdi = 1'b1; ch_func_in = 4'b1010; #1;
        chk("mux_a", ch_out, 4'b1101);
        chk("dbg_a", debug_tdi_o, 1);
        tap.chiptdi = 1'b0; ch_func_in = 4'b0000; #1;
        chk("mux_b", ch_out, 4'b0001);
        chk("dbg_b", debug_tdi_o, 0);
        ch_func_in = 4'b0111; #1;
        chk("mux_c", ch_out, 4'b0001);

        // Short write: error, TCR holds
        tcr_write(32'h8000FFFF, 31);
        chk("short_err", length_err_o, 1);
        chk("short_tcr", tcr_out, 32'h000040A7);
        tcr_read(rd);
        chk("readback", rd, 32'h800040A7);
        chk("read_err_keep", length_err_o, 1);
        chk("read_tcr_keep", tcr_out, 32'h000040A7);
        // Over-long write saturates the counter and still fails
        tcr_write(32'h80000009, 34);
        chk("long_err", length_err_o, 1);
        chk("long_tcr", tcr_out, 32'h000040A7);

        // Good write clears error; lane 0 on PRBS
        ch_func_in = 4'b0000;
        tcr_write(32'h80000009, 32);
        chk("good_err", length_err_o, 0);
        chk("good_tcr", tcr_out, 32'h00000009);
        for (int i = 0; i < 127; i++) begin
            prbs_ref[i] = m[0];
            chk("prbs", ch_out[0], m[0]);
            tick();
        end
        for (int i = 0; i < 127; i++) begin
            chk("prbs_period", ch_out[0], prbs_ref[i]);
            tick();
        end

        // GEN=0: pass-through, PRBS frozen
        tcr_write(32'h80000008, 32);
        for (int i = 0; i < 20; i++) begin
            ch_func_in[0] = i[0]; #1;
            chk("gen0_pass", ch_out[0], i[0]);
            tick();
        end
        ch_func_in = 4'b0000;
        tcr_write(32'h80000009, 32);
        for (int i = 0; i < 20; i++) begin
            chk("prbs_resume", ch_out[0], m[0]);
            tick();
        end

        // EXTEST capture/shift/update
        trcal_tr_in = 16'hA5C3;
        ex_bits = 16'hA5C3;
        tap.extest_sel = 1'b1;
        tap.capture_dr_i = 1'b1;
        tick();
        tap.capture_dr_i = 1'b0;
        tap.shift_dr_i = 1'b1;
        tap.chiptdi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("ex_bs", tap.bs_chain_tdi_o, ex_bits[i]);
            chk("ex_hold", trcal_tr_out, 0);
            tick();
        end
        chk("ex_bs_end", tap.bs_chain_tdi_o, 1);
        tap.shift_dr_i = 1'b0;
        tap.update_dr_i = 1'b1;
        tick();
        tap.update_dr_i = 1'b0;
        #1;
        chk("ex_upd", trcal_tr_out, 16'hFFFF);
        tap.capture_dr_i = 1'b1; tap.chiptdi = 1'b0;
        tick();
        tap.capture_dr_i = 1'b0; tap.shift_dr_i = 1'b1;
        tick(); tick(); tick();
        tap.shift_dr_i = 1'b0;
        chk("ex_keep", trcal_tr_out, 16'hFFFF);
        chk("ex_bs_cap", tap.bs_chain_tdi_o, ex_bits[3]);
        tap.extest_sel = 1'b0;

        // Mid-shift reset
        tcr_write(32'h0, 5);
        chk("pre_rst_err", length_err_o, 1);
        ch_func_in = 4'b0110;
        tap.sample_preload_sel = 1'b1;
        tap.capture_dr_i = 1'b1;
        tick();
        tap.capture_dr_i = 1'b0;
        tap.shift_dr_i = 1'b1;
        tap.chiptdi = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        test_logic_reset_i = 1'b1;
        tick();
        test_logic_reset_i = 1'b0;
        tap.shift_dr_i = 1'b0;
        #1;
        chk("mrst_tcr", tcr_out, 0);
        chk("mrst_err", length_err_o, 0);
        chk("mrst_tr", trcal_tr_out, 0);
        chk("mrst_ch", ch_out, 4'b0110);
        chk("mrst_bs", tap.bs_chain_tdi_o, 0);
        tap.update_dr_i = 1'b1;
        tick();
        tap.update_dr_i = 1'b0;
        tap.sample_preload_sel = 1'b0;
        #1;
        chk("mrst_upd_err", length_err_o, 1);
        chk("mrst_upd_tcr", tcr_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
